// File: rtl/jtag_pkg.sv
// Shared types and constants for the oversampled JTAG TAP.
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_EXIT2_DR   = 4'h0,
    TAP_EXIT1_DR   = 4'h1,
    TAP_SHIFT_DR   = 4'h2,
    TAP_PAUSE_DR   = 4'h3,
    TAP_SELECT_IR  = 4'h4,
    TAP_UPDATE_DR  = 4'h5,
    TAP_CAPTURE_DR = 4'h6,
    TAP_SELECT_DR  = 4'h7,
    TAP_EXIT2_IR   = 4'h8,
    TAP_EXIT1_IR   = 4'h9,
    TAP_SHIFT_IR   = 4'hA,
    TAP_PAUSE_IR   = 4'hB,
    TAP_RTI        = 4'hC,
    TAP_UPDATE_IR  = 4'hD,
    TAP_CAPTURE_IR = 4'hE,
    TAP_TLR        = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    SEL_BYPASS,
    SEL_IDCODE,
    SEL_USER
  } dr_sel_e;

  localparam logic [4:0] JTAG_IDCODE     = 5'h01;
  localparam logic [4:0] JTAG_BYPASS     = 5'h1F;
  localparam logic [4:0] JTAG_IR_CAPTURE = 5'b00001;

endpackage

// File: rtl/jtag_pin_sync.sv
// Two-flop synchronisers for the JTAG pins plus a TCK edge detector in the clk domain.
module jtag_pin_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tck,
  input  logic i_tms,
  input  logic i_tdi,
  input  logic i_trstn,
  output logic o_tms,
  output logic o_tdi,
  output logic o_trstn,
  output logic o_tck_rise,
  output logic o_tck_fall
);

  logic [1:0] r_tck_sync;
  logic [1:0] r_tms_sync;
  logic [1:0] r_tdi_sync;
  logic [1:0] r_trstn_sync;
  logic       r_tck_dly;

  // trstn resets low so the TAP is held in Test-Logic-Reset until the pin is seen high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tck_sync   <= 2'b00;
      r_tms_sync   <= 2'b11;
      r_tdi_sync   <= 2'b00;
      r_trstn_sync <= 2'b00;
      r_tck_dly    <= 1'b0;
    end else begin
      r_tck_sync   <= {r_tck_sync[0], i_tck};
      r_tms_sync   <= {r_tms_sync[0], i_tms};
      r_tdi_sync   <= {r_tdi_sync[0], i_tdi};
      r_trstn_sync <= {r_trstn_sync[0], i_trstn};
      r_tck_dly    <= r_tck_sync[1];
    end
  end

  assign o_tms      = r_tms_sync[1];
  assign o_tdi      = r_tdi_sync[1];
  assign o_trstn    = r_trstn_sync[1];
  assign o_tck_rise = r_tck_sync[1] & ~r_tck_dly;
  assign o_tck_fall = ~r_tck_sync[1] & r_tck_dly;

endmodule

// File: rtl/jtag_tap_oversampled.sv
// IEEE 1149.1 TAP sampled in the clk domain with IDCODE, BYPASS and a USER DR.
// Define JTAG_IDCODE_EN to implement the IDCODE instruction; otherwise its opcode decodes as BYPASS.
module jtag_tap_oversampled
  import jtag_pkg::*;
#(
  parameter int unsigned       IR_W       = 5,
  parameter int unsigned       DR_W       = 32,
  parameter logic [31:0]       IDCODE_VAL = 32'h1000_0DB3,
  parameter logic [IR_W-1:0]   USER_IR    = 5'h11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tck,
  input  logic            tms,
  input  logic            trstn,
  input  logic            tdi,
  output logic            tdo,
  output logic            tdo_oe,
  input  logic [DR_W-1:0] user_capture_data,
  output logic [DR_W-1:0] user_update_data,
  output logic            user_update_valid,
  output logic [3:0]      tap_state
);

`ifdef JTAG_IDCODE_EN
  localparam logic [IR_W-1:0] OP_IDCODE = IR_W'(JTAG_IDCODE);
  localparam logic [IR_W-1:0] OP_RESET  = OP_IDCODE;
`else
  localparam logic [IR_W-1:0] OP_RESET  = {IR_W{1'b1}};
`endif
  localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(JTAG_IR_CAPTURE);

  logic w_tms, w_tdi, w_trstn, w_tck_rise, w_tck_fall;
  logic w_act;

  tap_state_e      r_state, w_next_state;
  dr_sel_e         w_sel;
  logic [IR_W-1:0] r_ir, r_ir_sr;
  logic            r_byp;
  logic [31:0]     r_id_sr;
  logic [DR_W-1:0] r_usr_sr;
  logic            w_shift_ir, w_shift_dr, w_dr_lsb, w_tdo_next;

  jtag_pin_sync u_pin_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_tck      (tck),
    .i_tms      (tms),
    .i_tdi      (tdi),
    .i_trstn    (trstn),
    .o_tms      (w_tms),
    .o_tdi      (w_tdi),
    .o_trstn    (w_trstn),
    .o_tck_rise (w_tck_rise),
    .o_tck_fall (w_tck_fall)
  );

  // A synced trstn low masks any concurrent TCK rise.
  assign w_act = w_tck_rise & w_trstn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= TAP_TLR;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (!w_trstn) begin
      w_next_state = TAP_TLR;
    end else if (w_tck_rise) begin
      case (r_state)
        TAP_TLR:        w_next_state = w_tms ? TAP_TLR       : TAP_RTI;
        TAP_RTI:        w_next_state = w_tms ? TAP_SELECT_DR : TAP_RTI;
        TAP_SELECT_DR:  w_next_state = w_tms ? TAP_SELECT_IR : TAP_CAPTURE_DR;
        TAP_CAPTURE_DR: w_next_state = w_tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
        TAP_SHIFT_DR:   w_next_state = w_tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
        TAP_EXIT1_DR:   w_next_state = w_tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
        TAP_PAUSE_DR:   w_next_state = w_tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
        TAP_EXIT2_DR:   w_next_state = w_tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
        TAP_UPDATE_DR:  w_next_state = w_tms ? TAP_SELECT_DR : TAP_RTI;
        TAP_SELECT_IR:  w_next_state = w_tms ? TAP_TLR       : TAP_CAPTURE_IR;
        TAP_CAPTURE_IR: w_next_state = w_tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
        TAP_SHIFT_IR:   w_next_state = w_tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
        TAP_EXIT1_IR:   w_next_state = w_tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
        TAP_PAUSE_IR:   w_next_state = w_tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
        TAP_EXIT2_IR:   w_next_state = w_tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
        TAP_UPDATE_IR:  w_next_state = w_tms ? TAP_SELECT_DR : TAP_RTI;
      endcase
    end
  end

  always_comb begin
    w_sel = SEL_BYPASS;
    if (r_ir == USER_IR) w_sel = SEL_USER;
`ifdef JTAG_IDCODE_EN
    if (r_ir == OP_IDCODE) w_sel = SEL_IDCODE;
`endif
  end

  always_comb begin
    w_shift_ir = (r_state == TAP_SHIFT_IR);
    w_shift_dr = (r_state == TAP_SHIFT_DR);
    case (w_sel)
      SEL_IDCODE: w_dr_lsb = r_id_sr[0];
      SEL_USER:   w_dr_lsb = r_usr_sr[0];
      default:    w_dr_lsb = r_byp;
    endcase
    w_tdo_next = w_shift_ir ? r_ir_sr[0] : (w_shift_dr ? w_dr_lsb : 1'b0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir    <= OP_RESET;
      r_ir_sr <= '0;
    end else if (!w_trstn) begin
      r_ir    <= OP_RESET;
      r_ir_sr <= '0;
    end else begin
      if (r_state == TAP_TLR) r_ir <= OP_RESET;
      if (w_act) begin
        case (r_state)
          TAP_CAPTURE_IR: r_ir_sr <= IR_CAPTURE;
          TAP_SHIFT_IR:   r_ir_sr <= {w_tdi, r_ir_sr[IR_W-1:1]};
          TAP_UPDATE_IR:  r_ir    <= r_ir_sr;
          default:        ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byp    <= 1'b0;
      r_id_sr  <= '0;
      r_usr_sr <= '0;
    end else if (!w_trstn) begin
      r_byp    <= 1'b0;
      r_id_sr  <= '0;
      r_usr_sr <= '0;
    end else if (w_act) begin
      if (r_state == TAP_CAPTURE_DR) begin
        case (w_sel)
          SEL_IDCODE: r_id_sr  <= IDCODE_VAL;
          SEL_USER:   r_usr_sr <= user_capture_data;
          default:    r_byp    <= 1'b0;
        endcase
      end else if (r_state == TAP_SHIFT_DR) begin
        case (w_sel)
          SEL_IDCODE: r_id_sr  <= {w_tdi, r_id_sr[31:1]};
          SEL_USER:   r_usr_sr <= (r_usr_sr >> 1) | (DR_W'(w_tdi) << (DR_W - 1));
          default:    r_byp    <= w_tdi;
        endcase
      end
    end
  end

  // Update output survives trstn; only rst_n clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      user_update_data  <= '0;
      user_update_valid <= 1'b0;
    end else begin
      user_update_valid <= 1'b0;
      if (w_act && r_state == TAP_UPDATE_DR && w_sel == SEL_USER) begin
        user_update_data  <= r_usr_sr;
        user_update_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdo    <= 1'b0;
      tdo_oe <= 1'b0;
    end else if (w_tck_fall) begin
      tdo    <= w_tdo_next;
      tdo_oe <= w_shift_ir | w_shift_dr;
    end
  end

  assign tap_state = r_state;

endmodule

// File: doc/jtag_tap_oversampled.md
# jtag_tap_oversampled

Single-clock JTAG TAP controller that consumes the raw `tck`/`tms`/`trstn`/`tdi` pins driven by the JTAG bridge into `matrix_accelerator_soc` and produces `tdo` back to it. It oversamples the JTAG pins in the `clk` domain and detects TCK edges. It runs the IEEE 1149.1 16-state TAP FSM and implements IDCODE, BYPASS and one USER data register that exposes a parallel capture/update port to the SoC debug logic.

## Interface
- `IR_W`, 5, instruction register width.
- `DR_W`, 32, USER data register width, ≥ 1.
- `IDCODE_VAL`, 32'h1000_0DB3, IDCODE value; bit 0 must be 1.
- `USER_IR`, 5'h11, opcode selecting the USER data register.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tck`  in  1  JTAG clock, asynchronous to `clk`, treated as data.
- `tms`  in  1  JTAG mode select.
- `trstn`  in  1  JTAG reset, active-low.
- `tdi`  in  1  JTAG data in.
- `tdo`  out  1  JTAG data out.
- `tdo_oe`  out  1  high while in Shift-IR or Shift-DR.
- `user_capture_data`  in  DR_W  value loaded into the USER DR on Capture-DR.
- `user_update_data`  out  DR_W  USER DR contents latched on Update-DR.
- `user_update_valid`  out  1  one-cycle pulse when `user_update_data` changes.
- `tap_state`  out  4  current TAP state, encoded as `tap_state_e`.

## Operation
- Synchronisation: 2-FF synchronisers on `tck`, `tms`, `tdi`, `trstn`. Synchroniser reset values are 0, 1, 0, 0.
- Edge detection: a third flop on synced `tck`.
  - `tck_rise` = synced & ~delayed.
  - `tck_fall` = ~synced & delayed.
- TAP FSM: standard 1149.1 transitions on `tms` sampled at `tck_rise`.
- Test-Logic-Reset entry: forced whenever synced `trstn` = 0. Five consecutive `tms`=1 rises reach TLR from any state.
- Actions at `tck_rise`, based on the state at that edge:
  - Capture-IR: IR shift register loads `{IR_W-2 zeros, 2'b01}`.
  - Shift-IR: IR shift register does `{tdi, sr[IR_W-1:1]}`.
  - Update-IR: IR ← IR shift register.
  - Capture-DR: the selected DR loads its capture value.
    - IDCODE: `IDCODE_VAL`.
    - BYPASS: 0.
    - USER: `user_capture_data`.
  - Shift-DR: the selected DR shifts right with `tdi` entering the MSB. BYPASS is a 1-bit register.
  - Update-DR with USER selected: `user_update_data` ← USER shift register; `user_update_valid` pulses 1 cycle.
- IR decode:
  - IDCODE opcode is 5'h01.
  - BYPASS opcode is all ones.
  - `USER_IR` selects USER.
  - Any other value selects BYPASS.
- In TLR, IR is set to the IDCODE opcode.
- TDO: at `tck_fall`, `tdo` ← LSB of the active shift register (IR in Shift-IR, selected DR in Shift-DR); else `tdo` ← 0. `tdo_oe` is updated at the same edge.
- Reset values:
  - `tdo` = 0, `tdo_oe` = 0.
  - `user_update_data` = 0, `user_update_valid` = 0.
  - `tap_state` = TLR, IR = IDCODE opcode.

## Timing
- `tck_rise`/`tck_fall` are asserted 3 `clk` cycles after the pin edge.
- FSM and shift registers update on the `clk` edge where `tck_rise` = 1.
- `tdo` is valid 4 `clk` cycles after the TCK falling edge.
- TCK high and low phases must each be ≥ 4 `clk` periods. Behaviour is unspecified below that.
- `user_update_valid` is exactly one cycle, coincident with the `tap_state` transition out of Update-DR.
- Synced `trstn` low overrides any concurrent `tck_rise`.
- `rst_n` or `trstn` asserted mid-shift: shift contents are discarded; `user_update_data` keeps its value under `trstn`, but is cleared under `rst_n`.

## Configuration
- `JTAG_IDCODE_EN` defined: IDCODE instruction implemented as above.
- `JTAG_IDCODE_EN` undefined:
  - opcode 5'h01 decodes as BYPASS;
  - TLR loads the BYPASS opcode;
  - Capture-DR after reset yields a single 0 bit;
  - `IDCODE_VAL` is ignored.

## Structure
- `jtag_pkg`:
  - `tap_state_e` (4-bit, 16 states);
  - opcode constants `JTAG_IDCODE`, `JTAG_BYPASS`;
  - IR capture constant.
- Sub-module `jtag_pin_sync`: 2-FF synchronisers plus TCK edge detector. Outputs synced `tms`/`tdi`/`trstn`, `tck_rise`, `tck_fall`.

## Test plan
- Reset, then TMS 0 into RTI → Capture-DR → shift 32 bits: TDO stream LSB-first equals 32'h1000_0DB3, `tdo_oe`=1 only during shift.
- Load IR 5'h1F, shift DR with TDI pattern 1,0,1,1: TDO shows 0,1,0,1 (one-bit delay).
- Load IR 5'h11, `user_capture_data`=32'hCAFE_F00D, shift in 32'h1234_5678: shifted-out stream = CAFEF00D, `user_update_data`=32'h1234_5678 with one `user_update_valid` pulse.
- From Shift-DR, drive TMS=1 for 5 TCK rises: `tap_state` = TLR, IR = IDCODE, no update pulse.
- Assert `trstn`=0 for 3 `clk` cycles mid-Shift-IR: TLR within 3 cycles, previous `user_update_data` retained; then IDCODE readback succeeds.
- Build without `JTAG_IDCODE_EN`: DR read after reset yields a single 0 then TDI passthrough; IR 5'h01 behaves as BYPASS.
